// File: rtl/apb_pkg.sv
// Shared APB definitions used by the APB requester bridge and by the APB
// slaves: FSM state encoding, byte width and the PSTRB width helper.
package apb_pkg;

  localparam int APB_BYTE_WIDTH = 8;

  // Requester FSM encoding. fsm_state debug outputs carry these values.
  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_SETUP_ENC  = 2'd1;
  localparam logic [1:0] ST_ACCESS_ENC = 2'd2;
  localparam logic [1:0] ST_RESP_ENC   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_SETUP  = ST_SETUP_ENC,
    ST_ACCESS = ST_ACCESS_ENC,
    ST_RESP   = ST_RESP_ENC
  } apb_state_e;

  // Number of PSTRB lanes for a given data width.
  function automatic int strb_width(input int data_width);
    return data_width / APB_BYTE_WIDTH;
  endfunction

endpackage

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB4 requester.
// Accepts one command on the req_* valid/ready port, runs an APB SETUP then
// ACCESS phase, and returns read data / error status on the rsp_* port.
// A wait-state counter aborts transfers whose slave holds PREADY low for
// TIMEOUT_CYCLES consecutive ACCESS cycles (0 disables the timeout).
//
// Handshakes: a transfer happens on a rising PCLK edge where valid and ready
// are both high; valid, once raised, holds its payload until that edge.
// req_ready is high only in IDLE; rsp_valid is high only in RESP.
//
// Ports:
//   PCLK, PRESETn              clock, async active-low reset
//   req_valid/ready/write/addr/wdata/strb   command port
//   rsp_valid/ready/rdata/err/timeout       response port
//   PADDR/PWRITE/PWDATA/PSTRB/PSEL/PENABLE  APB request (all registered)
//   PRDATA/PREADY/PSLVERR                   APB completion
//   fsm_state                  current FSM state (apb_pkg encoding)
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                PCLK,
  input  logic                                PRESETn,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic                                req_write,
  input  logic [ADDR_WIDTH-1:0]               req_addr,
  input  logic [DATA_WIDTH-1:0]               req_wdata,
  input  logic [strb_width(DATA_WIDTH)-1:0]   req_strb,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [DATA_WIDTH-1:0]               rsp_rdata,
  output logic                                rsp_err,
  output logic                                rsp_timeout,
  output logic [ADDR_WIDTH-1:0]               PADDR,
  output logic                                PWRITE,
  output logic [DATA_WIDTH-1:0]               PWDATA,
  output logic [strb_width(DATA_WIDTH)-1:0]   PSTRB,
  output logic                                PSEL,
  output logic                                PENABLE,
  input  logic [DATA_WIDTH-1:0]               PRDATA,
  input  logic                                PREADY,
  input  logic                                PSLVERR,
  output logic [1:0]                          fsm_state
);

  // At least one bit so TIMEOUT_CYCLES=0 still elaborates.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  apb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt;
  logic              timeout_hit;

  // This PREADY-low cycle is the TIMEOUT_CYCLES-th consecutive one.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  assign req_ready = (state_q == ST_IDLE);
  assign fsm_state = state_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (PREADY || timeout_hit) state_d = ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so no req_* input
  // reaches an APB pin combinationally.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      PSEL      <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      PENABLE   <= (state_d == ST_ACCESS);
      rsp_valid <= (state_d == ST_RESP);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      wait_cnt    <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && req_valid) begin
        PADDR    <= req_addr;
        PWRITE   <= req_write;
        PWDATA   <= req_wdata;
        PSTRB    <= req_write ? req_strb : '0;
        wait_cnt <= '0;
      end
      if (state_q == ST_ACCESS) begin
        if (PREADY) begin
          rsp_rdata   <= PWRITE ? '0 : PRDATA;
          rsp_err     <= PSLVERR;
          rsp_timeout <= 1'b0;
        end else begin
          if (wait_cnt != '1) wait_cnt <= wait_cnt + CNT_W'(1);
          if (timeout_hit) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: behavioural APB memory slave with
// programmable wait states, an error address and a stuck-PREADY mode.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [SW-1:0] req_strb = '0;
  logic          rsp_valid, rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, rsp_timeout;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic          PSEL, PENABLE;
  logic [DW-1:0] PRDATA;
  logic          PREADY, PSLVERR;
  logic [1:0]    fsm_state;

  apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 PCLK = ~PCLK;

  // ---------------- APB slave model ----------------
  logic [DW-1:0] mem [64];
  int            slave_wait = 0;
  logic          slave_stuck = 1'b0;
  int            acc_cnt = 0;
  localparam logic [AW-1:0] ERR_ADDR = 8'hF0;

  assign PREADY  = !slave_stuck && (acc_cnt >= slave_wait);
  assign PSLVERR = PREADY && (PADDR == ERR_ADDR);
  assign PRDATA  = (PADDR == ERR_ADDR) ? 32'hFFFF_FFFF : mem[PADDR[7:2]];

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE && PADDR != ERR_ADDR)
      for (int b = 0; b < SW; b++)
        if (PSTRB[b]) mem[PADDR[7:2]][b*8 +: 8] <= PWDATA[b*8 +: 8];
  end

  // ---------------- scoreboard ----------------
  logic [DW+1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int            wait_n;
    logic          stuck;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    logic          exp_to;
  } vec_t;

  // Drives one command with rsp_ready high and checks the response,
  // latency from acceptance, ACCESS length and request fields.
  task automatic do_vec(input vec_t v, input string tag);
    int lat, acc, exp_acc;
    logic [SW-1:0] strb_seen;
    logic [AW-1:0] addr_seen;
    logic [DW+1:0] e;
    slave_wait  = v.wait_n;
    slave_stuck = v.stuck;
    rsp_ready   = 1'b1;
    @(negedge PCLK);
    req_valid = 1'b1; req_write = v.write; req_addr = v.addr;
    req_wdata = v.wdata; req_strb = v.strb;
    exp_q.push_back({v.exp_rdata, v.exp_err, v.exp_to});
    check({tag, " req_ready"}, 64'(req_ready), 64'd1);
    @(negedge PCLK);            // accepted at the edge in between
    req_valid = 1'b0;
    req_wdata = '1; req_addr = '1; req_strb = '1;  // must not leak into APB
    lat = 1; acc = 0; strb_seen = '0; addr_seen = '0;
    while (!rsp_valid && lat < 100) begin
      if (lat == 1) begin strb_seen = PSTRB; addr_seen = PADDR; end
      if (PSEL && PENABLE) acc++;
      @(negedge PCLK);
      lat++;
    end
    if (!rsp_valid) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout waiting rsp_valid", tag);
      void'(exp_q.pop_front());
      return;
    end
    exp_acc = v.stuck ? TO : v.wait_n + 1;
    e = exp_q.pop_front();
    check({tag, " rsp_rdata"},   64'(rsp_rdata),   64'(e[DW+1:2]));
    check({tag, " rsp_err"},     64'(rsp_err),     64'(e[1]));
    check({tag, " rsp_timeout"}, 64'(rsp_timeout), 64'(e[0]));
    check({tag, " latency"},     64'(lat),         64'(exp_acc + 2));
    check({tag, " access_cyc"},  64'(acc),         64'(exp_acc));
    check({tag, " PSTRB"},       64'(strb_seen),   64'(v.write ? v.strb : '0));
    check({tag, " PADDR"},       64'(addr_seen),   64'(v.addr));
    check({tag, " PSEL in RESP"}, 64'({PSEL, PENABLE}), 64'd0);
    @(negedge PCLK);
    check({tag, " back to idle"}, 64'({req_ready, rsp_valid}), 64'b10);
    slave_stuck = 1'b0;
    slave_wait  = 0;
  endtask

  vec_t vecs[11];

  initial begin
    logic [DW-1:0] held;
    int guard;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[1] = 32'hCAFE_BABE;     // address 0x04

    vecs[0]  = '{1'b1, 8'h10, 32'hA5A5_1234, 4'hF, 0, 1'b0, 32'h0,         1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h10, 32'h0,         4'hF, 0, 1'b0, 32'hA5A5_1234, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h20, 32'h0,         4'hF, 0, 1'b0, 32'h0,         1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h20, 32'hFFFF_FFFF, 4'h3, 0, 1'b0, 32'h0,         1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h20, 32'h0,         4'hF, 0, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h04, 32'h0,         4'h0, 3, 1'b0, 32'hCAFE_BABE, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'hF0, 32'h0,         4'h0, 0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 8'hF0, 32'h1234_5678, 4'hF, 1, 1'b0, 32'h0,         1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h30, 32'h0,         4'h0, 0, 1'b1, 32'h0,         1'b1, 1'b1};
    vecs[9]  = '{1'b1, 8'h08, 32'h0BAD_F00D, 4'hC, 2, 1'b0, 32'h0,         1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h08, 32'h0,         4'h0, 0, 1'b0, 32'h0BAD_0000, 1'b0, 1'b0};

    // ---- reset state ----
    #12;
    check("reset req_ready", 64'(req_ready), 64'd1);
    check("reset ctl", 64'({rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE}), 64'd0);
    check("reset data", 64'({rsp_rdata, PADDR, PSTRB}), 64'd0);
    check("reset PWDATA", 64'(PWDATA), 64'd0);
    check("reset fsm_state", 64'(fsm_state), 64'(ST_IDLE_ENC));
    @(negedge PCLK);
    PRESETn = 1'b1;

    // ---- table-driven transfers ----
    for (int i = 0; i < 11; i++) do_vec(vecs[i], $sformatf("vec%0d", i));

    // ---- response backpressure ----
    rsp_ready = 1'b0;
    @(negedge PCLK);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10;
    exp_q.push_back({32'hA5A5_1234, 1'b0, 1'b0});
    @(negedge PCLK);
    req_valid = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 50) begin @(negedge PCLK); guard++; end
    check("bp rsp_valid seen", 64'(rsp_valid), 64'd1);
    held = exp_q[0][DW+1:2];
    for (int k = 0; k < 5; k++) begin
      check("bp hold", 64'({rsp_valid, req_ready, rsp_err, rsp_timeout}), 64'b1000);
      check("bp rdata", 64'(rsp_rdata), 64'(held));
      @(negedge PCLK);
    end
    rsp_ready = 1'b1;
    void'(exp_q.pop_front());
    @(negedge PCLK);
    check("bp release", 64'({rsp_valid, req_ready}), 64'b01);

    // ---- reset during ACCESS ----
    slave_stuck = 1'b1;
    @(negedge PCLK);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h3C; req_wdata = 32'h1; req_strb = 4'hF;
    @(negedge PCLK);
    req_valid = 1'b0;
    guard = 0;
    while (!PENABLE && guard < 20) begin @(negedge PCLK); guard++; end
    check("rst mid ACCESS reached", 64'({PSEL, PENABLE}), 64'b11);
    #2 PRESETn = 1'b0;
    #1;
    check("rst async ctl", 64'({PSEL, PENABLE, rsp_valid}), 64'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    slave_stuck = 1'b0;
    check("rst req_ready after", 64'(req_ready), 64'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge PCLK);
      check("rst no response", 64'({rsp_valid, PSEL}), 64'd0);
    end
    check("rst write lost", 64'(mem[15]), 64'd0);
    check("scoreboard empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global time limit");
    $fatal(1, "time limit");
  end

endmodule
